mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM->WB pipeline register with valid/ready flow control, flush, and an optional 2-entry skid buffer.
- Carries regDest, result and write-enable from the MEM stage to the WB stage.
- Adds the following over a plain pipeline latch: backpressure, bubble tracking, r0 write suppression, and a stall counter.
- Instantiated once, between MEM and the register-file write port.

Parameters:
- WORD_W, 32, width of the result word.
- REG_ADDR_W, 5, width of the destination register address.
- SKID, 1: 1 = registered in_ready with a 2-entry skid buffer; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all held and incoming entries.
- in_valid  in  1  MEM entry valid.
- in_ready  out  1  stage can accept an entry.
- in_regDest  in  REG_ADDR_W  destination register.
- in_result  in  WORD_W  result value.
- in_wen  in  1  entry writes the register file.
- out_valid  out  1  WB entry valid.
- out_ready  in  1  WB consumes the entry.
- out_regDest  out  REG_ADDR_W  destination register to WB.
- out_result  out  WORD_W  result value to WB.
- out_wen  out  1  write enable to WB (0 if regDest==0).
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs and internal registers go to 0, state goes to EMPTY, stall_cnt goes to 0.
  - in_ready is 1 from the first cycle after reset.
- Handshake:
  - Accept = in_valid & in_ready. Consume = out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Latency and throughput: accepted entry appears on out_* one cycle after acceptance; sustained throughput is 1 entry/cycle.
- r0 suppression: the stored wen is in_wen & (in_regDest != 0). regDest and result are still passed through.
- State machine for SKID=1 (main register plus skid register):
  - EMPTY: accept -> ONE (main <= in).
  - ONE, accept and consume -> ONE (main <= in).
  - ONE, accept and no consume -> FULL (skid <= in).
  - ONE, consume only -> EMPTY.
  - FULL: in_ready=0. Consume -> ONE (main <= skid). No consume -> stay FULL.
  - in_ready is a registered signal equal to (state != FULL).
- SKID=0:
  - States are EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept with consume in the same cycle reloads main.
- flush:
  - Next state is EMPTY regardless of accept or consume in the same cycle. An entry accepted in the flush cycle is dropped.
  - out_valid is 0 the cycle after flush. Data registers may retain stale values, but out_wen is forced 0 whenever out_valid=0.
  - in_ready is not gated by flush.
- Simultaneous rst and flush: rst wins; the result is identical (EMPTY).
- stall_cnt:
  - Increments on each cycle with out_valid & !out_ready.
  - Saturates at all-ones; no wrap-around.
  - Cleared only by rst; flush does not clear it.
- Invariant: out_valid=0 implies out_wen=0 and out_regDest=0 presented to WB.

Decomposition:
- Shared package holds WORD_W and REG_ADDR_W defaults (matching the global word and register-address bus widths), the state encoding (EMPTY=0, ONE=1, FULL=2), and a wb_entry_t struct {regDest, result, wen}.
- One natural sub-module: sat_counter (CNT_W, inc, clear), reusable for other stall counters.
- Skid logic stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_wen=0, stall_cnt=0; in_ready=1 on the first cycle after rst falls.
- Streaming: out_ready=1, entries {rd=3,res=0x11}, {rd=4,res=0x22}, {rd=5,res=0x33} on consecutive cycles -> the same values on out_* one cycle later each, no bubbles.
- Backpressure (SKID=1): out_ready=0, push {rd=7,0xAA} then {rd=8,0xBB}:
  - in_ready drops to 0 the cycle after the second accept.
  - out_* hold {7,0xAA}.
  - After 3 stalled cycles, stall_cnt=3.
  - Raise out_ready -> 0xAA then 0xBB drain in order, and in_ready returns to 1.
- r0 suppression: in {rd=0, res=0xDEAD, wen=1} -> out_wen=0, out_result=0xDEAD.
- Flush in FULL state with a simultaneous accept -> out_valid=0 next cycle, the accepted entry never appears, stall_cnt unchanged.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared MEM->WB definitions: default bus widths, stage state encoding
// and the write-back entry bundle.
package mem_wb_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regDest;
        logic [WORD_W-1:0]     result;
        logic                  wen;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: valid/ready flow control, flush, optional
// 2-entry skid buffer, r0 write suppression and a saturating stall counter.
module mem_wb_stage #(
    parameter int WORD_W     = mem_wb_pkg::WORD_W,
    parameter int REG_ADDR_W = mem_wb_pkg::REG_ADDR_W,
    parameter int SKID       = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_regDest,
    input  logic [WORD_W-1:0]     in_result,
    input  logic                  in_wen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_regDest,
    output logic [WORD_W-1:0]     out_result,
    output logic                  out_wen,
    output logic [CNT_W-1:0]      stall_cnt
);

    import mem_wb_pkg::*;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regDest;
        logic [WORD_W-1:0]     result;
        logic                  wen;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_e;
    logic   full_q, full_d;
    logic   accept;
    logic   consume;

    always_comb begin
        in_e         = '0;
        in_e.regDest = in_regDest;
        in_e.result  = in_result;
        in_e.wen     = in_wen && (in_regDest != '0);
    end

    // Skid mode registers ready; otherwise ready looks through to WB.
    assign in_ready  = (SKID != 0) ? ~full_q : (~out_valid | out_ready);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = in_e;
                end else if (accept) begin
                    skid_d  = in_e;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            full_q  <= full_d;
        end
    end

    // WB never sees a write target or enable from a bubble.
    assign out_regDest = out_valid ? main_q.regDest : '0;
    assign out_result  = main_q.result;
    assign out_wen     = out_valid & main_q.wen;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk),
        .clear_i(rst),
        .inc_i  (out_valid & ~out_ready),
        .cnt_o  (stall_cnt)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Random + directed bench for mem_wb_stage (SKID=0 and SKID=1 side by side)
// against a queue-based reference model.
module tb_mem_wb_stage;

    import mem_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_regDest;
    logic [31:0] in_result;
    logic        in_wen;
    logic        out_ready;
    bit          armed;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int g, input string nm,
                       input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL skid%0d %s got=%0h want=%0h @%0t",
                     g, nm, act, expv, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        ir;
        logic        ov;
        logic        ow;
        logic [4:0]  ord;
        logic [31:0] ores;
        logic [3:0]  sc;
        wb_entry_t   exp_q[$];
        int          stall_m;
        bit          ready_m;

        mem_wb_stage #(
            .WORD_W    (32),
            .REG_ADDR_W(5),
            .SKID      (g),
            .CNT_W     (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (ir),
            .in_regDest (in_regDest),
            .in_result  (in_result),
            .in_wen     (in_wen),
            .out_valid  (ov),
            .out_ready  (out_ready),
            .out_regDest(ord),
            .out_result (ores),
            .out_wen    (ow),
            .stall_cnt  (sc)
        );

        // Model: accepted entries queue up; capacity 2 with skid, else 1.
        always @(posedge clk) begin : model
            wb_entry_t e;
            if (rst) begin
                exp_q.delete();
                stall_m = 0;
            end else if (flush) begin
                exp_q.delete();
            end else if (in_valid && ready_m) begin
                e.regDest = in_regDest;
                e.result  = in_result;
                e.wen     = in_wen && (in_regDest != 5'd0);
                exp_q.push_back(e);
            end
        end

        always @(negedge clk) begin : monitor
            if (g == 1) ready_m = (exp_q.size() != 2);
            else        ready_m = (exp_q.size() == 0) || out_ready;
            if (armed) begin
                chk(g, "in_ready", 32'(ir), 32'(ready_m));
                chk(g, "out_valid", 32'(ov), 32'(exp_q.size() > 0));
                chk(g, "stall_cnt", 32'(sc), 32'(stall_m));
                if (exp_q.size() > 0) begin
                    chk(g, "out_regDest", 32'(ord), 32'(exp_q[0].regDest));
                    chk(g, "out_result", ores, exp_q[0].result);
                    chk(g, "out_wen", 32'(ow), 32'(exp_q[0].wen));
                end else begin
                    chk(g, "idle_wen", 32'(ow), 32'd0);
                    chk(g, "idle_regDest", 32'(ord), 32'd0);
                end
            end
            if (exp_q.size() > 0) begin
                if (out_ready) void'(exp_q.pop_front());
                else if (stall_m < 15) stall_m++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic [31:0] res,
                        input logic wen);
        in_valid   = 1'b1;
        in_regDest = rd;
        in_result  = res;
        in_wen     = wen;
        step();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        armed      = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_regDest = 5'd9;
        in_result  = 32'h99;
        in_wen     = 1'b1;
        step();
        armed = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk(1, "ready_after_rst", 32'(g_dut[1].ir), 32'd1);
        chk(1, "stall_after_rst", 32'(g_dut[1].sc), 32'd0);
        step();

        out_ready = 1'b1;
        send(5'd3, 32'h11, 1'b1);
        send(5'd4, 32'h22, 1'b1);
        send(5'd5, 32'h33, 1'b1);
        in_valid = 1'b0;
        step();
        step();

        out_ready = 1'b0;
        send(5'd7, 32'hAA, 1'b1);
        send(5'd8, 32'hBB, 1'b1);
        in_valid = 1'b0;
        step();
        step();
        step();
        chk(1, "bp_ready_low", 32'(g_dut[1].ir), 32'd0);
        chk(1, "bp_hold", g_dut[1].ores, 32'hAA);
        out_ready = 1'b1;
        step();
        step();
        step();

        send(5'd0, 32'hDEAD, 1'b1);
        in_valid = 1'b0;
        step();
        step();

        out_ready = 1'b0;
        send(5'd1, 32'h101, 1'b1);
        send(5'd2, 32'h202, 1'b1);
        flush = 1'b1;
        send(5'd3, 32'h303, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk(1, "flush_empty", 32'(g_dut[1].ov), 32'd0);
        step();
        out_ready = 1'b1;
        step();
        step();

        out_ready = 1'b0;
        send(5'd6, 32'h66, 1'b1);
        in_valid = 1'b0;
        repeat (20) step();
        chk(0, "sat_15", 32'(g_dut[0].sc), 32'd15);
        chk(1, "sat_15", 32'(g_dut[1].sc), 32'd15);
        out_ready = 1'b1;
        step();

        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 119) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_regDest = 5'($urandom_range(0, 31));
            in_result  = $urandom;
            in_wen     = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
